// File: rtl/udp_pkg.sv
// udp_pkg: shared UDP constants and the transmit FSM state encoding.
package udp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CALC_SUM,
    FOLD,
    WAIT_ACK,
    SEND_HEAD,
    SEND_DATA,
    SEND_END
  } udp_state_e;

  localparam logic [7:0]  UDP_PROTO        = 8'h11;
  localparam logic [7:0]  UDP_HDR_LEN      = 8'd8;
  localparam logic [15:0] UDP_DEF_SRC_PORT = 16'd8080;
  localparam logic [15:0] UDP_DEF_DST_PORT = 16'd8080;
  localparam logic [15:0] UDP_DEF_MAX_LEN  = 16'd1472;

endpackage

// File: rtl/udp_csum_acc.sv
// udp_csum_acc: seeded 32-bit accumulator of 16-bit words with ones'-complement fold and invert.
module udp_csum_acc (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_load,
  input  logic [31:0] i_seed,
  input  logic        i_add,
  input  logic [15:0] i_word,
  output logic [15:0] o_csum
);

  logic [31:0] r_sum;
  logic [16:0] w_fold1;
  logic [15:0] w_fold2;
  logic [15:0] w_inv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum <= '0;
    end else if (i_load) begin
      r_sum <= i_seed;
    end else if (i_add) begin
      r_sum <= r_sum + {16'h0000, i_word};
    end
  end

  // The second fold cannot carry out: a carry from the first leaves at most 16'hFFFE below it.
  assign w_fold1 = {1'b0, r_sum[31:16]} + {1'b0, r_sum[15:0]};
  assign w_fold2 = w_fold1[15:0] + {15'h0000, w_fold1[16]};
  assign w_inv   = ~w_fold2;
  assign o_csum  = (w_inv == 16'h0000) ? 16'hFFFF : w_inv;

endmodule

// File: rtl/udp_tx.sv
// udp_tx: builds the UDP header and streams the payload from the send RAM to the IP layer.
// Define UDP_TX_CHECKSUM_EN to compute the checksum; otherwise the checksum field is sent as zero.
module udp_tx
  import udp_pkg::*;
#(
  parameter logic [15:0] SRC_PORT = UDP_DEF_SRC_PORT,
  parameter logic [15:0] DST_PORT = UDP_DEF_DST_PORT,
  parameter logic [15:0] MAX_LEN  = UDP_DEF_MAX_LEN
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tx_start,
  input  logic [15:0] tx_data_length,
  input  logic [31:0] ip_src_addr,
  input  logic [31:0] ip_dst_addr,
  input  logic [7:0]  ram_rdata,
  output logic [10:0] ram_raddr,
  input  logic        ip_tx_ack,
  output logic        udp_tx_req,
  output logic [15:0] udp_tx_length,
  output logic [7:0]  udp_tx_data,
  output logic        udp_tx_valid,
  output logic        udp_tx_end,
  output logic        tx_busy,
  output logic        tx_err
);

  udp_state_e  r_state;
  logic [15:0] r_len;
  logic [2:0]  r_hdrIdx;
  logic [15:0] r_dataIdx;
  logic [7:0]  w_hdrByte;
  logic [15:0] w_csumField;
  logic        w_lenOk;
  logic [15:0] w_udpLen;

  assign w_lenOk  = (tx_data_length != 16'd0) && (tx_data_length <= MAX_LEN);
  assign w_udpLen = tx_data_length + {8'h00, UDP_HDR_LEN};

`ifdef UDP_TX_CHECKSUM_EN
  logic [15:0] r_cnt;
  logic [15:0] r_csum;
  logic [7:0]  r_hiByte;
  logic [15:0] w_byteIdx;
  logic [15:0] w_csum;
  logic [15:0] w_word;
  logic [31:0] w_seed;
  logic        w_load;
  logic        w_add;
  logic        w_lastByte;

  // Pseudo-header plus UDP header words; the length appears in both.
  assign w_seed = {16'h0000, ip_src_addr[31:16]} + {16'h0000, ip_src_addr[15:0]}
                + {16'h0000, ip_dst_addr[31:16]} + {16'h0000, ip_dst_addr[15:0]}
                + {24'h000000, UDP_PROTO} + {16'h0000, w_udpLen}
                + {16'h0000, SRC_PORT} + {16'h0000, DST_PORT} + {16'h0000, w_udpLen};

  // RAM data lags the address by two edges, so byte k is consumed when r_cnt is k+1.
  assign w_byteIdx  = r_cnt - 16'd1;
  assign w_lastByte = (w_byteIdx == r_len - 16'd1);
  assign w_load     = (r_state == IDLE) && tx_start && w_lenOk;
  assign w_add      = (r_state == CALC_SUM) && (r_cnt != 16'd0) && (w_byteIdx[0] || w_lastByte);
  assign w_word     = w_byteIdx[0] ? {r_hiByte, ram_rdata} : {ram_rdata, 8'h00};
  assign w_csumField = r_csum;

  udp_csum_acc u_csumAcc (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_load),
    .i_seed (w_seed),
    .i_add  (w_add),
    .i_word (w_word),
    .o_csum (w_csum)
  );
`else
  logic w_unused;
  assign w_unused    = ^{ip_src_addr, ip_dst_addr};
  assign w_csumField = 16'h0000;
`endif

  always_comb begin
    w_hdrByte = SRC_PORT[15:8];
    case (r_hdrIdx)
      3'd1:    w_hdrByte = SRC_PORT[7:0];
      3'd2:    w_hdrByte = DST_PORT[15:8];
      3'd3:    w_hdrByte = DST_PORT[7:0];
      3'd4:    w_hdrByte = udp_tx_length[15:8];
      3'd5:    w_hdrByte = udp_tx_length[7:0];
      3'd6:    w_hdrByte = w_csumField[15:8];
      3'd7:    w_hdrByte = w_csumField[7:0];
      default: w_hdrByte = SRC_PORT[15:8];
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_len         <= '0;
      r_hdrIdx      <= '0;
      r_dataIdx     <= '0;
      ram_raddr     <= '0;
      udp_tx_req    <= 1'b0;
      udp_tx_length <= '0;
      udp_tx_data   <= '0;
      udp_tx_valid  <= 1'b0;
      udp_tx_end    <= 1'b0;
      tx_busy       <= 1'b0;
      tx_err        <= 1'b0;
`ifdef UDP_TX_CHECKSUM_EN
      r_cnt         <= '0;
      r_csum        <= '0;
      r_hiByte      <= '0;
`endif
    end else begin
      tx_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (tx_start && !w_lenOk) begin
            tx_err <= 1'b1;
          end else if (tx_start) begin
            r_len         <= tx_data_length;
            udp_tx_length <= w_udpLen;
            ram_raddr     <= '0;
            tx_busy       <= 1'b1;
`ifdef UDP_TX_CHECKSUM_EN
            r_cnt         <= '0;
            r_state       <= CALC_SUM;
`else
            udp_tx_req    <= 1'b1;
            r_state       <= WAIT_ACK;
`endif
          end
        end
`ifdef UDP_TX_CHECKSUM_EN
        CALC_SUM: begin
          ram_raddr <= ram_raddr + 11'd1;
          r_cnt     <= r_cnt + 16'd1;
          if (r_cnt != 16'd0) begin
            r_hiByte <= ram_rdata;
            if (w_lastByte) begin
              r_state <= FOLD;
            end
          end
        end
        FOLD: begin
          r_csum     <= w_csum;
          udp_tx_req <= 1'b1;
          r_state    <= WAIT_ACK;
        end
`endif
        WAIT_ACK: begin
          if (ip_tx_ack) begin
            udp_tx_req   <= 1'b0;
            udp_tx_valid <= 1'b1;
            udp_tx_data  <= SRC_PORT[15:8];
            r_hdrIdx     <= 3'd1;
            ram_raddr    <= '0;
            r_state      <= SEND_HEAD;
          end
        end
        // Address 0 is held through the header so payload byte 0 is ready right after it.
        SEND_HEAD: begin
          udp_tx_data <= w_hdrByte;
          r_hdrIdx    <= r_hdrIdx + 3'd1;
          if (r_hdrIdx == 3'd7) begin
            ram_raddr <= 11'd1;
            r_dataIdx <= '0;
            r_state   <= SEND_DATA;
          end
        end
        SEND_DATA: begin
          udp_tx_data <= ram_rdata;
          ram_raddr   <= ram_raddr + 11'd1;
          r_dataIdx   <= r_dataIdx + 16'd1;
          if (r_dataIdx == r_len - 16'd1) begin
            udp_tx_end <= 1'b1;
            r_state    <= SEND_END;
          end
        end
        SEND_END: begin
          udp_tx_valid <= 1'b0;
          udp_tx_end   <= 1'b0;
          tx_busy      <= 1'b0;
          r_state      <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_udp_tx.sv
// tb_udp_tx: directed bench for udp_tx; a negedge monitor scores the byte stream against a queue
// filled when each frame is started.
module tb_udp_tx;

  localparam logic [15:0] SRC    = 16'd8080;
  localparam logic [15:0] DST    = 16'd8080;
  localparam int          MAXLEN = 1472;

  logic        clk;
  logic        rst_n;
  logic        tx_start;
  logic [15:0] tx_data_length;
  logic [31:0] ip_src_addr;
  logic [31:0] ip_dst_addr;
  logic [7:0]  ram_rdata;
  logic [10:0] ram_raddr;
  logic        ip_tx_ack;
  logic        udp_tx_req;
  logic [15:0] udp_tx_length;
  logic [7:0]  udp_tx_data;
  logic        udp_tx_valid;
  logic        udp_tx_end;
  logic        tx_busy;
  logic        tx_err;

  logic [7:0]  mem [0:2047];
  logic [8:0]  expQ [$];
  logic [8:0]  monExp;
  logic        inFrame = 1'b0;
  int          checks = 0;
  int          errors = 0;
  int          w;
  int          seen;
  logic [15:0] zw;

  udp_tx dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .tx_start       (tx_start),
    .tx_data_length (tx_data_length),
    .ip_src_addr    (ip_src_addr),
    .ip_dst_addr    (ip_dst_addr),
    .ram_rdata      (ram_rdata),
    .ram_raddr      (ram_raddr),
    .ip_tx_ack      (ip_tx_ack),
    .udp_tx_req     (udp_tx_req),
    .udp_tx_length  (udp_tx_length),
    .udp_tx_data    (udp_tx_data),
    .udp_tx_valid   (udp_tx_valid),
    .udp_tx_end     (udp_tx_end),
    .tx_busy        (tx_busy),
    .tx_err         (tx_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous send RAM: data appears one cycle after the address.
  always @(posedge clk) ram_rdata <= mem[ram_raddr];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic longint pseudoSum(input int len);
    longint s;
    logic [15:0] ulen;
    ulen = 16'(len + 8);
    s = 0;
    s += longint'(ip_src_addr[31:16]);
    s += longint'(ip_src_addr[15:0]);
    s += longint'(ip_dst_addr[31:16]);
    s += longint'(ip_dst_addr[15:0]);
    s += 64'h11;
    s += longint'(ulen);
    s += longint'(SRC);
    s += longint'(DST);
    s += longint'(ulen);
    return s;
  endfunction

  function automatic logic [15:0] foldSum(input longint v);
    longint s;
    s = v;
    while (s > 64'hFFFF) s = (s & 64'hFFFF) + (s >> 16);
    return s[15:0];
  endfunction

  function automatic logic [15:0] goldCsum(input int len);
    longint      s;
    logic [15:0] r;
    logic [7:0]  lo;
    s = pseudoSum(len);
    for (int i = 0; i < len; i += 2) begin
      lo = (i + 1 < len) ? mem[i + 1] : 8'h00;
      s += longint'({mem[i], lo});
    end
    r = ~foldSum(s);
    return (r == 16'h0000) ? 16'hFFFF : r;
  endfunction

  // Scoreboard consumer: every valid byte must match the next queued {end, data}.
  always @(negedge clk) begin
    if (!rst_n) begin
      inFrame = 1'b0;
      expQ.delete();
    end else begin
      if (inFrame) checkOutput("streamContiguous", udp_tx_valid, 1);
      if (udp_tx_valid) begin
        checkOutput("byteWasExpected", expQ.size() != 0, 1);
        if (expQ.size() != 0) begin
          monExp = expQ.pop_front();
          checkOutput("streamByte", {udp_tx_end, udp_tx_data}, monExp);
        end
        inFrame = !udp_tx_end;
      end
    end
  end

  task automatic applyStimulus(input int len, input logic ackHigh);
    logic [63:0] hdr;
    logic [15:0] cs;
`ifdef UDP_TX_CHECKSUM_EN
    cs = goldCsum(len);
`else
    cs = 16'h0000;
`endif
    hdr = {SRC, DST, 16'(len + 8), cs};
    for (int k = 0; k < 8; k++) expQ.push_back({1'b0, hdr[63 - 8*k -: 8]});
    for (int i = 0; i < len; i++) expQ.push_back({(i == len - 1), mem[i]});
    ip_tx_ack      = ackHigh;
    tx_data_length = 16'(len);
    tx_start       = 1'b1;
    @(posedge clk); #1;
    tx_start = 1'b0;
    checkOutput("busyAfterStart", tx_busy, 1);
    checkOutput("noErrOnGoodStart", tx_err, 0);
`ifdef UDP_TX_CHECKSUM_EN
    checkOutput("noReqWhileSumming", udp_tx_req, 0);
`else
    checkOutput("reqOneCycleAfterStart", udp_tx_req, 1);
`endif
  endtask

  task automatic finishFrame(input int len, input logic checkLat);
    int n;
    int firstN;
    int bound;
    n      = 0;
    firstN = -1;
    bound  = (len + 1) / 2 + len + 6;
    while (tx_busy && n < 2 * len + 100) begin
      @(posedge clk); #1;
      n++;
      if (udp_tx_valid && firstN < 0) firstN = n;
    end
    checkOutput("frameCompleted", tx_busy, 0);
    checkOutput("allBytesSent", expQ.size(), 0);
    checkOutput("lengthField", udp_tx_length, 16'(len + 8));
    checkOutput("reqIdleAfterFrame", udp_tx_req, 0);
    if (checkLat) checkOutput("firstHeaderLatency", (firstN > 0) && (firstN <= bound), 1);
  endtask

  task automatic rejectStart(input int len);
    tx_data_length = 16'(len);
    tx_start       = 1'b1;
    @(posedge clk); #1;
    tx_start = 1'b0;
    checkOutput("errPulse", tx_err, 1);
    checkOutput("busyStaysLow", tx_busy, 0);
    checkOutput("noReqOnReject", udp_tx_req, 0);
    @(posedge clk); #1;
    checkOutput("errOneCycle", tx_err, 0);
    checkOutput("stillIdle", tx_busy, 0);
  endtask

  task automatic checkAllZero(input string phase);
    checkOutput({phase, ".req"}, udp_tx_req, 0);
    checkOutput({phase, ".valid"}, udp_tx_valid, 0);
    checkOutput({phase, ".end"}, udp_tx_end, 0);
    checkOutput({phase, ".busy"}, tx_busy, 0);
    checkOutput({phase, ".err"}, tx_err, 0);
    checkOutput({phase, ".data"}, udp_tx_data, 0);
    checkOutput({phase, ".raddr"}, ram_raddr, 0);
    checkOutput({phase, ".length"}, udp_tx_length, 0);
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_n          = 1'b1;
    tx_start       = 1'b0;
    ip_tx_ack      = 1'b0;
    tx_data_length = '0;
    ip_src_addr    = 32'hC0A80102;
    ip_dst_addr    = 32'hC0A80103;
    for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
    #1 rst_n = 1'b0;
    #2;
    checkAllZero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Four-byte frame between 192.168.1.2 and 192.168.1.3
    mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h03; mem[3] = 8'h04;
    applyStimulus(4, 1'b1);
    finishFrame(4, 1'b1);

    // Odd length pads the final byte
    mem[4] = 8'h05;
    applyStimulus(5, 1'b1);
    finishFrame(5, 1'b1);

    // Minimum length
    mem[0] = 8'hA5;
    applyStimulus(1, 1'b1);
    finishFrame(1, 1'b1);

    // Out-of-range lengths are rejected
    rejectStart(0);
    rejectStart(MAXLEN + 1);

    // Delayed grant, with a start attempt ignored while busy
    for (int i = 0; i < 6; i++) mem[i] = 8'(8'h10 + i);
    applyStimulus(6, 1'b0);
    w = 0;
    while (!udp_tx_req && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    checkOutput("reqRaised", udp_tx_req, 1);
    for (int i = 0; i < 20; i++) begin
      checkOutput("reqHeldUntilAck", udp_tx_req, 1);
      checkOutput("noValidBeforeAck", udp_tx_valid, 0);
      if (i == 4) begin
        checkOutput("startIgnoredWhileBusy", tx_err, 0);
        tx_start = 1'b0;
      end
      if (i == 3) begin
        tx_data_length = 16'd0;
        tx_start       = 1'b1;
      end
      @(posedge clk); #1;
    end
    ip_tx_ack = 1'b1;
    @(posedge clk); #1;
    ip_tx_ack = 1'b0;
    checkOutput("reqDropsAfterAck", udp_tx_req, 0);
    checkOutput("firstByteAfterAck", udp_tx_valid, 1);
    finishFrame(6, 1'b0);

    // Payload chosen so the ones'-complement sum is all ones
    zw = ~foldSum(pseudoSum(2));
    mem[0] = zw[15:8];
    mem[1] = zw[7:0];
    applyStimulus(2, 1'b1);
    finishFrame(2, 1'b1);

    // Largest accepted payload
    for (int i = 0; i < MAXLEN; i++) mem[i] = 8'($urandom_range(0, 255));
    applyStimulus(MAXLEN, 1'b1);
    finishFrame(MAXLEN, 1'b1);

    // Reset in the middle of the payload, then a clean frame
    for (int i = 0; i < 8; i++) mem[i] = 8'(8'hC0 + i);
    applyStimulus(8, 1'b1);
    seen = 0;
    w    = 0;
    while (seen < 10 && w < 200) begin
      @(posedge clk); #1;
      w++;
      if (udp_tx_valid) seen++;
    end
    checkOutput("reachedPayload", seen, 10);
    rst_n = 1'b0;
    #1;
    checkAllZero("midFrameReset");
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) mem[i] = 8'(8'h30 + i);
    applyStimulus(3, 1'b1);
    finishFrame(3, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/udp_tx.md
UDP_TX -- requirements
Module: udp_tx

Interface
REQ-001 SHALL have parameter SRC_PORT, default 16'd8080, UDP source port.
REQ-002 SHALL have parameter DST_PORT, default 16'd8080, UDP destination port.
REQ-003 SHALL have parameter MAX_LEN, default 16'd1472, largest accepted payload length in bytes.
REQ-004 clk  in  1  clock; all logic on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 tx_start  in  1  one-cycle pulse requesting transmission of the payload held in the send RAM.
REQ-007 tx_data_length  in  16  payload byte count, sampled on tx_start.
REQ-008 ip_src_addr, ip_dst_addr  in  32 each  pseudo-header addresses, sampled on tx_start.
REQ-009 ram_rdata  in  8  send-RAM read data, valid 1 cycle after ram_raddr.
REQ-010 ram_raddr  out  11  send-RAM read address.
REQ-011 ip_tx_ack  in  1  IP layer grants the request and is ready to take bytes next cycle.
REQ-012 udp_tx_req  out  1  request to the IP layer; udp_tx_length  out  16  UDP length, 8 plus payload length.
REQ-013 udp_tx_data  out  8, udp_tx_valid  out  1, udp_tx_end  out  1: byte stream, qualifier, last-byte marker.
REQ-014 tx_busy  out  1, tx_err  out  1: busy indicator and one-cycle pulse when a start is rejected.

Function
REQ-015 States: IDLE, CALC_SUM, FOLD, WAIT_ACK, SEND_HEAD, SEND_DATA, SEND_END.
REQ-016 IDLE -> CALC_SUM on tx_start with length 1..MAX_LEN; a start with length 0 or above MAX_LEN pulses tx_err next cycle and stays IDLE.
REQ-017 tx_start outside IDLE is ignored, with no tx_err.
REQ-018 CALC_SUM: read RAM addresses 0..len-1 in order; the 32-bit accumulator adds big-endian 16-bit words; an odd final byte is padded as {byte,8'h00}.
REQ-019 The accumulator is seeded with src hi+lo, dst hi+lo, 16'h0011 and udp_tx_length.
REQ-020 The header word SRC_PORT+DST_PORT+udp_tx_length is also added.
REQ-021 FOLD: fold twice ({16'b0,sum[31:16]}+sum[15:0]), then invert; a result of 16'h0000 is transmitted as 16'hFFFF.
REQ-022 WAIT_ACK: udp_tx_req=1 until ip_tx_ack; the request drops the cycle after ack; SEND_HEAD is entered on ack.
REQ-023 SEND_HEAD: 8 consecutive valid bytes: SRC_PORT, DST_PORT, length, checksum, each MSB first.
REQ-024 SEND_DATA: payload bytes 0..len-1 follow the last header byte with no gap; ram_raddr is prefetched so there are no bubbles.
REQ-025 udp_tx_end=1 with the final payload byte only.
REQ-026 SEND_END: one cycle with valid=0, then IDLE.
REQ-027 tx_busy=1 in every state except IDLE.
REQ-028 Latency: with ip_tx_ack held high, the first header byte appears at most ceil(len/2)+len+6 cycles after tx_start.
REQ-029 Length is captured in a 16-bit register; udp_tx_length = len+8 with no overflow possible given MAX_LEN.

Reset
REQ-030 On rst_n low, asynchronously: state=IDLE; udp_tx_req, udp_tx_valid, udp_tx_end, tx_busy, tx_err = 0.
REQ-031 On rst_n low, asynchronously: udp_tx_data, ram_raddr, udp_tx_length and the accumulator = 0.
REQ-032 Reset mid-frame aborts the frame immediately; no udp_tx_end is produced.

Configuration
REQ-033 Macro UDP_TX_CHECKSUM_EN defined: behaviour per REQ-018..021.
REQ-034 Macro UDP_TX_CHECKSUM_EN undefined: CALC_SUM and FOLD are removed, IDLE goes directly to WAIT_ACK, and the checksum field is 16'h0000.

Structure
REQ-035 A shared package udp_pkg SHALL hold the state encoding, UDP_PROTO=8'h11, UDP_HDR_LEN=8 and the default port constants.
REQ-036 One sub-module, udp_csum_acc (seeded 32-bit word accumulator plus fold/invert), SHALL be instantiated; udp_rx MAY reuse it.

Verification
REQ-037 len=4, RAM=01 02 03 04, ip 192.168.1.2->192.168.1.3, ports 8080/8080 -> 12 bytes out, length field 0x000C, checksum matches a golden model, end flag on byte 04.
REQ-038 len=5 -> odd byte padded in the sum; 13 bytes out; length 0x000D.
REQ-039 tx_start with len=0, then with len=1473 -> tx_err pulses, tx_busy stays 0, no req.
REQ-040 ip_tx_ack delayed 20 cycles -> udp_tx_req held steady for 20 cycles, no valid bytes early, stream contiguous afterward.
REQ-041 Payload crafted so the raw checksum is 0 -> field is 0xFFFF; with UDP_TX_CHECKSUM_EN undefined, the field is 0x0000 and req rises 1 cycle after start.
REQ-042 rst_n asserted during SEND_DATA, then released and a new start issued -> outputs zero at once, next frame correct.
